// File: rtl/mgmt_spi_pkg.sv
// rtl/mgmt_spi_pkg.sv - shared constants and types for the management SPI slave
package mgmt_spi_pkg;

  localparam int         SPI_BITS_PER_BYTE = 8;
  localparam logic [7:0] SPI_IDLE_BYTE     = 8'h00;
  localparam int         SPI_CNT_W         = $clog2(SPI_BITS_PER_BYTE);

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } spi_state_e;

  // Byte to shift out at a byte start: the pending reply, or the idle filler.
  function automatic logic [SPI_BITS_PER_BYTE-1:0] pick_reply(
    input logic                         valid,
    input logic [SPI_BITS_PER_BYTE-1:0] data
  );
    return valid ? data : SPI_IDLE_BYTE;
  endfunction

endpackage

// File: rtl/mgmt_sync2.sv
// rtl/mgmt_sync2.sv - two-flop synchronizer with a parameterised reset value
module mgmt_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mgmt_spi_slave.sv
// rtl/mgmt_spi_slave.sv - oversampled SPI mode-0 slave for the management engine
module mgmt_spi_slave
  import mgmt_spi_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         spi_sck,
  input  logic                         spi_cs_n_pin,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  output logic                         spi_rx_data_valid,
  output logic [SPI_BITS_PER_BYTE-1:0] spi_rx_data,
  output logic                         spi_cs_falling,
  output logic                         spi_cs_n,
  input  logic                         spi_tx_data_valid,
  input  logic [SPI_BITS_PER_BYTE-1:0] spi_tx_data,
  output logic                         tx_overrun
);

  localparam int W = SPI_BITS_PER_BYTE;

  logic sck_s, cs_n_s, mosi_s;

  mgmt_sync2 #(.RESET_VAL(1'b0)) u_sync_sck  (.clk_i(clk), .rst_i(rst), .d_i(spi_sck),      .q_o(sck_s));
  mgmt_sync2 #(.RESET_VAL(1'b1)) u_sync_cs   (.clk_i(clk), .rst_i(rst), .d_i(spi_cs_n_pin), .q_o(cs_n_s));
  mgmt_sync2 #(.RESET_VAL(1'b0)) u_sync_mosi (.clk_i(clk), .rst_i(rst), .d_i(spi_mosi),     .q_o(mosi_s));

  spi_state_e           state_q, state_d;
  logic                 sck_prev_q, cs_n_prev_q;
  logic [1:0]           settle_q, settle_d;
  logic [SPI_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [W-2:0]         rx_shift_q, rx_shift_d;
  logic [W-1:0]         rx_data_q, rx_data_d;
  logic [W-1:0]         tx_shift_q, tx_shift_d;
  logic [W-1:0]         pend_q, pend_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 cs_fall_q, cs_fall_d;
  logic                 miso_q, miso_d;
  logic                 pend_valid_q, pend_valid_d;
  logic                 ovr_q, ovr_d;
  logic                 sck_rise, sck_fall, cs_fall, consume, drop_pend, ovr_event;
  logic [W-1:0]         reply;

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  // Ignore CS# falls until the synchronizer has flushed its reset preset, so a
  // pin already low at reset release cannot look like a fresh assertion.
  assign cs_fall  = (settle_q == 2'd3) & cs_n_prev_q & ~cs_n_s;
  assign reply    = pick_reply(pend_valid_q, pend_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sck_prev_q   <= 1'b0;
      cs_n_prev_q  <= 1'b1;
      settle_q     <= 2'd0;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      tx_shift_q   <= '0;
      pend_q       <= '0;
      rx_valid_q   <= 1'b0;
      cs_fall_q    <= 1'b0;
      miso_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sck_prev_q   <= sck_s;
      cs_n_prev_q  <= cs_n_s;
      settle_q     <= settle_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      tx_shift_q   <= tx_shift_d;
      pend_q       <= pend_d;
      rx_valid_q   <= rx_valid_d;
      cs_fall_q    <= cs_fall_d;
      miso_q       <= miso_d;
      pend_valid_q <= pend_valid_d;
      ovr_q        <= ovr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_d     = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    tx_shift_d   = tx_shift_q;
    pend_d       = pend_q;
    rx_valid_d   = 1'b0;
    cs_fall_d    = 1'b0;
    miso_d       = miso_q;
    pend_valid_d = pend_valid_q;
    consume      = 1'b0;
    drop_pend    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d    = ST_ACTIVE;
          cs_fall_d  = 1'b1;
          bit_cnt_d  = '0;
          tx_shift_d = reply << 1;
          miso_d     = reply[W-1];
          consume    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_n_s) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          miso_d    = 1'b0;
          drop_pend = 1'b1;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[W-3:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + SPI_CNT_W'(1);
          if (bit_cnt_q == SPI_CNT_W'(W - 1)) begin
            rx_data_d  = {rx_shift_q, mosi_s};
            rx_valid_d = 1'b1;
          end
        end else if (sck_fall) begin
          if (bit_cnt_q != '0) begin
            miso_d     = tx_shift_q[W-1];
            tx_shift_d = tx_shift_q << 1;
          end else begin
            miso_d     = reply[W-1];
            tx_shift_d = reply << 1;
            consume    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A strobe landing on a consume cycle refills the just-emptied slot, so it
    // is not an overrun.
    ovr_event = spi_tx_data_valid & pend_valid_q & ~consume & ~drop_pend;
    if (consume || drop_pend) pend_valid_d = 1'b0;
    if (spi_tx_data_valid) begin
      pend_d       = spi_tx_data;
      pend_valid_d = 1'b1;
    end
    ovr_d = (cs_fall_d ? 1'b0 : ovr_q) | ovr_event;
  end

  assign spi_miso          = miso_q;
  assign spi_rx_data_valid = rx_valid_q;
  assign spi_rx_data       = rx_data_q;
  assign spi_cs_falling    = cs_fall_q;
  assign spi_cs_n          = cs_n_s;
  assign tx_overrun        = ovr_q;

endmodule

// File: doc/mgmt_spi_slave.md
MGMT_SPI_SLAVE -- requirements
Module: mgmt_spi_slave

Interface
REQ-001 SHALL have port clk, input, 1, management engine clock; all logic in this domain.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port spi_sck, input, 1, SPI clock from STM32 master, asynchronous to clk.
REQ-004 SHALL have port spi_cs_n_pin, input, 1, SPI chip select from master, active low, asynchronous to clk.
REQ-005 SHALL have port spi_mosi, input, 1, master-out data, asynchronous to clk.
REQ-006 SHALL have port spi_miso, output, 1, slave-out data; drives 0 while deselected.
REQ-007 SHALL have port spi_rx_data_valid, output, 1, one-cycle pulse: a complete byte is on spi_rx_data.
REQ-008 SHALL have port spi_rx_data, output, 8, last received byte; held until the next byte completes.
REQ-009 SHALL have port spi_cs_falling, output, 1, one-cycle pulse on synchronized CS# assertion.
REQ-010 SHALL have port spi_cs_n, output, 1, synchronized CS# level (debug).
REQ-011 SHALL have port spi_tx_data_valid, input, 1, one-cycle strobe: spi_tx_data is the next reply byte.
REQ-012 SHALL have port spi_tx_data, input, 8, reply byte.
REQ-013 SHALL have port tx_overrun, output, 1, sticky: a pending reply byte was overwritten before transmission.

Function
REQ-014 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit bytes.
REQ-015 SHALL pass spi_sck, spi_cs_n_pin, spi_mosi each through a 2-flop synchronizer, detect edges by comparing each synchronized value with its previous-cycle value, and sample MOSI from the synchronized copy.
REQ-016 SHALL guarantee correct operation when each SCK high and low phase lasts at least 8 clk cycles; faster SCK is unsupported.
REQ-017 SHALL pulse spi_cs_falling for exactly one cycle, 3 clk after the CS# pin falls, and in that same cycle clear the 3-bit bit counter and load the TX shift register from the pending byte (0x00 if none).
REQ-018 On each synchronized SCK rising edge with CS# low SHALL shift MOSI into the RX shift register LSB and increment the bit counter (wraps 7->0).
REQ-019 On the 8th rising edge of a byte SHALL update spi_rx_data with the assembled byte and pulse spi_rx_data_valid in the same cycle; rx-pin-to-valid latency is 3 clk.
REQ-020 On each synchronized SCK falling edge with CS# low and bit counter nonzero SHALL drive spi_miso from TX shift MSB and shift left.
REQ-021 On a falling edge with bit counter zero (byte boundary) SHALL load TX shift from the pending byte (0x00 if none), drive its MSB onto spi_miso, and clear pending-valid.
REQ-022 spi_tx_data_valid SHALL latch spi_tx_data into the pending register and set pending-valid; if pending-valid was already set, the new byte overwrites and tx_overrun sets.
REQ-023 If spi_tx_data_valid coincides with a byte-boundary consume, the old pending byte SHALL be transmitted, the new byte SHALL become pending, and tx_overrun SHALL NOT set.
REQ-024 A reply strobed within 4 clk after spi_rx_data_valid SHALL be transmitted in the immediately following byte.
REQ-025 CS# deassertion mid-byte SHALL discard the partial byte (no spi_rx_data_valid), clear pending-valid and the bit counter, and force spi_miso to 0.
REQ-026 SCK edges while synchronized CS# is high SHALL be ignored.
REQ-027 tx_overrun SHALL clear on spi_cs_falling; a simultaneous overrun event in that cycle sets it.

Reset
REQ-028 On rst: spi_miso=0, spi_rx_data_valid=0, spi_rx_data=0x00, spi_cs_falling=0, spi_cs_n=1, tx_overrun=0, pending-valid=0, bit counter=0, synchronizers preset idle (SCK 0, CS# 1, MOSI 0).
REQ-029 Reset release while CS# pin is already low SHALL NOT generate spi_cs_falling; the block waits for the next CS# assertion.

Structure
REQ-030 SPI_BITS_PER_BYTE (8) and SPI_IDLE_BYTE (0x00) SHALL live in shared package mgmt_spi_pkg.
REQ-031 The synchronizer SHALL be sub-module mgmt_sync2 (2-flop, reset-to-parameter value), instantiated three times.

Verification
REQ-032 CS# falls, master sends 0x01,0x00 -> one spi_cs_falling pulse, then spi_rx_data_valid with 0x01, then 0x00; MISO reads 0x00,0x00.
REQ-033 After 2nd opcode byte, bench strobes 0x55 within 2 clk -> master reads 0x55 on the 3rd byte; tx_overrun stays 0.
REQ-034 Bench strobes 0x12 then 0x34 before the next boundary -> master reads 0x34, tx_overrun=1; next CS# fall clears it.
REQ-035 CS# rises after 5 bits of 0xA5 -> no spi_rx_data_valid; next transaction 0x3C received correctly.
REQ-036 Strobe 0x78 on exactly the boundary-consume cycle while 0x56 pending -> master reads 0x56 then 0x78, tx_overrun=0.
REQ-037 rst asserted mid-byte with SCK toggling -> all outputs at REQ-028 values within 1 clk; clean byte 0xC3 received after next CS# assertion.
